// File: rtl/auth_tag_gen.sv
// auth_tag_gen: absorbs a stream of message words under a session key and
// emits a short authentication tag once the final word has been absorbed.
// Each word is XORed with the low key slice, folded down to TAG_WIDTH bits
// and mixed into a rotating accumulator; the key rotates between words.
module auth_tag_gen #(
    parameter int KEY_WIDTH  = 256,
    parameter int TAG_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [KEY_WIDTH-1:0]  key_in,
    input  logic [TAG_WIDTH-1:0]  key_tag_bits,
    input  logic                  msg_valid,
    input  logic [DATA_WIDTH-1:0] msg_data,
    input  logic                  msg_last,
    output logic                  msg_ready,
    output logic [TAG_WIDTH-1:0]  tag,
    output logic                  tag_valid,
    input  logic                  tag_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ABSORB = 2'd1,
        S_FINAL  = 2'd2,
        S_OUT    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [KEY_WIDTH-1:0]    key_q, key_d;
    logic [TAG_WIDTH-1:0]    acc_q, acc_d;
    logic [15:0]             count_q, count_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;

    logic                    accept;
    logic [KEY_WIDTH-1:0]    key_base;
    logic [TAG_WIDTH-1:0]    acc_base;
    logic [15:0]             count_base;
    logic [TAG_WIDTH-1:0]    count_tag;

    // XOR of every TAG_WIDTH-bit slice of a data word
    function automatic logic [TAG_WIDTH-1:0] fold_word(input logic [DATA_WIDTH-1:0] w);
        logic [TAG_WIDTH-1:0] f;
        f = '0;
        for (int i = 0; i < DATA_WIDTH / TAG_WIDTH; i++) begin
            f = f ^ w[i*TAG_WIDTH +: TAG_WIDTH];
        end
        return f;
    endfunction

    function automatic logic [TAG_WIDTH-1:0] rotl1(input logic [TAG_WIDTH-1:0] a);
        return {a[TAG_WIDTH-2:0], a[TAG_WIDTH-1]};
    endfunction

    // Shift form keeps this valid even when the key is a single word wide
    function automatic logic [KEY_WIDTH-1:0] key_rotr(input logic [KEY_WIDTH-1:0] k);
        return (k >> DATA_WIDTH) | (k << (KEY_WIDTH - DATA_WIDTH));
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Low TAG_WIDTH bits of the word count, zero-extended for wide tags
    if (TAG_WIDTH > 16) begin : g_cnt_wide
        assign count_tag = {{(TAG_WIDTH-16){1'b0}}, count_q};
    end else begin : g_cnt_narrow
        assign count_tag = count_q[TAG_WIDTH-1:0];
    end

    assign accept = msg_valid & msg_ready;

    // A word accepted in IDLE starts a fresh message from the key-generator inputs
    assign key_base   = (state_q == S_IDLE) ? key_in       : key_q;
    assign acc_base   = (state_q == S_IDLE) ? key_tag_bits : acc_q;
    assign count_base = (state_q == S_IDLE) ? 16'd0        : count_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_ABSORB: begin
                if (accept) begin
                    state_d = msg_last ? S_FINAL : S_ABSORB;
                end
            end
            S_FINAL: state_d = S_OUT;
            S_OUT: begin
                if (tag_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        msg_ready = (state_q == S_IDLE) || (state_q == S_ABSORB);
        busy      = (state_q != S_IDLE);
        tag_valid = (state_q == S_OUT);
    end

    // Absorb step on each accepted word; tag capture in FINAL
    always_comb begin
        key_d   = key_q;
        acc_d   = acc_q;
        count_d = count_q;
        tag_d   = tag_q;
        if (accept) begin
            key_d   = key_rotr(key_base);
            acc_d   = rotl1(acc_base) ^ fold_word(msg_data ^ key_base[DATA_WIDTH-1:0]);
            count_d = sat_inc(count_base);
        end
        if (state_q == S_FINAL) begin
            tag_d = acc_q ^ count_tag;
        end
    end

    // Datapath registers, cleared by reset so no partial message survives it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q   <= '0;
            acc_q   <= '0;
            count_q <= '0;
            tag_q   <= '0;
        end else begin
            key_q   <= key_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            tag_q   <= tag_d;
        end
    end

    assign tag = tag_q;

endmodule

// File: doc/auth_tag_gen.md
AUTH_TAG_GEN -- requirements
Module: auth_tag_gen

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 256: width of key_in and the internal key register.
REQ-002 SHALL have parameter TAG_WIDTH, default 8: width of key_tag_bits and tag.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: message word width; KEY_WIDTH and DATA_WIDTH SHALL be multiples of TAG_WIDTH, and KEY_WIDTH a multiple of DATA_WIDTH.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port key_in  input  KEY_WIDTH  session key from the key generator stage.
REQ-007 SHALL have port key_tag_bits  input  TAG_WIDTH  tag seed from the key generator stage.
REQ-008 SHALL have port msg_valid  input  1  msg_data/msg_last valid.
REQ-009 SHALL have port msg_data  input  DATA_WIDTH  message word.
REQ-010 SHALL have port msg_last  input  1  marks the final word of a message.
REQ-011 SHALL have port msg_ready  output  1  block accepts a message word this cycle.
REQ-012 SHALL have port tag  output  TAG_WIDTH  computed authentication tag.
REQ-013 SHALL have port tag_valid  output  1  tag is valid.
REQ-014 SHALL have port tag_ready  input  1  consumer accepts tag.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ABSORB, FINAL, OUT.
REQ-017 Word accepted SHALL mean msg_valid and msg_ready both high at a rising clk edge.
REQ-018 msg_ready SHALL be high in IDLE and ABSORB, low in FINAL and OUT.
REQ-019 On a word accepted in IDLE: key_reg SHALL load key_in, acc SHALL start from key_tag_bits, count SHALL start from 0, then that word is absorbed in the same edge; key_in and key_tag_bits are ignored at all other times.
REQ-020 Absorb step: mix = msg_data XOR key_reg[DATA_WIDTH-1:0]; fold = XOR of all TAG_WIDTH-bit slices of mix; acc <= rotate-left-by-1(acc) XOR fold.
REQ-021 After each absorbed word, key_reg SHALL rotate right by DATA_WIDTH bits (wraps every KEY_WIDTH/DATA_WIDTH words).
REQ-022 count SHALL be 16-bit, increment per absorbed word, saturate at 16'hFFFF.
REQ-023 Transitions: IDLE->ABSORB on accepted word with msg_last=0; IDLE->FINAL or ABSORB->FINAL on accepted word with msg_last=1; ABSORB holds while msg_valid low.
REQ-024 FINAL SHALL last one cycle: tag <= acc XOR count[TAG_WIDTH-1:0] (zero-extended if TAG_WIDTH>16); state -> OUT.
REQ-025 In OUT tag_valid SHALL be high and tag stable until tag_ready high at a rising edge, then state -> IDLE with tag_valid low next cycle.
REQ-026 Latency: tag_valid SHALL first assert in the second cycle after the edge accepting the msg_last word.
REQ-027 Single-word message (msg_last in IDLE) SHALL be supported with identical latency.
REQ-028 msg_data/msg_last presented while msg_ready low SHALL be ignored, not queued.
REQ-029 tag_ready asserted outside OUT SHALL have no effect.

Reset
REQ-030 On reset high, asynchronously: state IDLE, tag_valid 0, tag 0, busy 0, key_reg 0, acc 0, count 0; msg_ready 1 once reset is released.
REQ-031 Reset mid-message or mid-OUT SHALL discard all partial state; no tag emitted for that message.

Verification
REQ-032 key_in=0, key_tag_bits=8'h00, single word 32'h01020304 msg_last=1 -> tag_valid 2 cycles later, tag=8'h05.
REQ-033 key_in[31:0]=32'hFFFFFFFF rest 0, key_tag_bits=8'h80, words 32'h00000000 then 32'h000000FF(last) -> tag=8'hFF.
REQ-034 REQ-032 stimulus with tag_ready held low 5 cycles -> tag_valid and tag=8'h05 stable 5 cycles, msg_ready low throughout; tag_ready high -> IDLE, msg_ready high.
REQ-035 msg_valid gaps of 3 cycles between words of REQ-033 -> same tag 8'hFF; key_in changed after first word -> tag unchanged.
REQ-036 reset pulsed after 2nd word of a 4-word message -> outputs at reset values, no tag_valid; following REQ-032 message -> tag=8'h05.
